button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_pkg.sv | 14 +
 rtl/button_debounce_channel.sv | 102 ++++++++++
 rtl/button_debouncer.sv | 32 +++
 tb/tb_button_debouncer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and defaults for the button debouncer.
// Imported by the channel and top-level modules.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } debounce_state_t;

  localparam int unsigned N_BUTTONS_DEFAULT = 4;

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: synchronizer, debounce FSM,
// press strobe and sticky press flag.
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic event_clear,
  output logic button_state,
  output logic press_pulse,
  output logic press_event
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic            sync_q1;
  logic            sync_q2;
  logic [CW-1:0]   cnt;
  debounce_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Outputs are updated on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RELEASED;
      cnt          <= '0;
      button_state <= 1'b0;
      press_pulse  <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (sync_q2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_q2) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state        <= PRESSED;
            cnt          <= '0;
            button_state <= 1'b1;
            press_pulse  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!sync_q2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync_q2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state        <= RELEASED;
            cnt          <= '0;
            button_state <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state        <= RELEASED;
          cnt          <= '0;
          button_state <= 1'b0;
        end
      endcase
    end
  end

  // A pulse wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_event <= 1'b0;
    end else begin
      press_event <= press_pulse |
                     (press_event & ~event_clear);
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer; one independent
// channel instance per button.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned N_BUTTONS = N_BUTTONS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] button_raw,
  input  logic [N_BUTTONS-1:0] event_clear,
  output logic [N_BUTTONS-1:0] button_state,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] press_event
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw         (button_raw[i]),
      .event_clear (event_clear[i]),
      .button_state(button_state[i]),
      .press_pulse (press_pulse[i]),
      .press_event (press_event[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: two debouncers (4- and 2-cycle)
// against a run-length reference model.
module tb_button_debouncer;

  localparam int NB = 4;
  localparam int DA = 4;
  localparam int DB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] raw = '0;
  logic [NB-1:0] clr = '0;
  logic [NB-1:0] st_a, pl_a, ev_a;
  logic [NB-1:0] st_b, pl_b, ev_b;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DA),
    .N_BUTTONS(NB)
  ) u_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .button_raw  (raw),
    .event_clear (clr),
    .button_state(st_a),
    .press_pulse (pl_a),
    .press_event (ev_a)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DB),
    .N_BUTTONS(NB)
  ) u_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .button_raw  (raw),
    .event_clear (clr),
    .button_state(st_b),
    .press_pulse (pl_b),
    .press_event (ev_b)
  );

  typedef struct packed {
    logic [NB-1:0] st;
    logic [NB-1:0] pl;
    logic [NB-1:0] ev;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  exp_t          exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;

  // Reference model: sampled level lags raw by two edges;
  // a level is accepted after D+1 consecutive differing samples.
  logic [NB-1:0] dq[$];
  logic [NB-1:0] acc[2];
  logic [NB-1:0] mpl[2];
  logic [NB-1:0] mev[2];
  int            run[2][NB];

  function automatic int dlen(input int m);
    return (m == 0) ? DA : DB;
  endfunction

  function automatic void model_reset();
    dq.delete();
    dq.push_back('0);
    dq.push_back('0);
    for (int m = 0; m < 2; m++) begin
      acc[m] = '0;
      mpl[m] = '0;
      mev[m] = '0;
      for (int i = 0; i < NB; i++) run[m][i] = 0;
    end
  endfunction

  function automatic void step(input logic [NB-1:0] r,
                               input logic [NB-1:0] c);
    logic [NB-1:0] s;
    logic [NB-1:0] pn;
    logic [NB-1:0] en;
    obs_t          o[2];
    exp_t          e;
    s = dq.pop_front();
    dq.push_back(r);
    for (int m = 0; m < 2; m++) begin
      pn = '0;
      en = mpl[m] | (mev[m] & ~c);
      for (int i = 0; i < NB; i++) begin
        if (s[i] != acc[m][i]) begin
          run[m][i] = run[m][i] + 1;
          if (run[m][i] == dlen(m) + 1) begin
            acc[m][i] = s[i];
            run[m][i] = 0;
            pn[i] = s[i];
          end
        end else begin
          run[m][i] = 0;
        end
      end
      mpl[m] = pn;
      mev[m] = en;
      o[m].st = acc[m];
      o[m].pl = pn;
      o[m].ev = en;
    end
    e.a = o[0];
    e.b = o[1];
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string nm, input int d,
                     input logic [NB-1:0] got,
                     input logic [NB-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s D=%0d got=%b exp=%b t=%0t",
               nm, d, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic rn,
                     input logic [NB-1:0] r,
                     input logic [NB-1:0] c);
    exp_t z;
    z = '0;
    @(negedge clk);
    rst_n = rn;
    raw   = r;
    clr   = c;
    if (!rn) begin
      model_reset();
      #1;
      chk("rst_state", DA, st_a, '0);
      chk("rst_pulse", DA, pl_a, '0);
      chk("rst_event", DA, ev_a, '0);
      chk("rst_state", DB, st_b, '0);
      exp_q.push_back(z);
    end else begin
      step(r, c);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("button_state", DA, st_a, e.a.st);
        chk("press_pulse",  DA, pl_a, e.a.pl);
        chk("press_event",  DA, ev_a, e.a.ev);
        chk("button_state", DB, st_b, e.b.st);
        chk("press_pulse",  DB, pl_b, e.b.pl);
        chk("press_event",  DB, ev_b, e.b.ev);
      end
    end
  end

  initial begin : stim
    logic [NB-1:0] r;
    logic [NB-1:0] c;
    logic          rn;
    bit            seen;
    model_reset();
    cyc(1'b0, '0, '0);
    cyc(1'b0, '0, '0);
    // clean press on channel 0
    repeat (10) cyc(1'b1, 4'h1, '0);
    repeat (10) cyc(1'b1, 4'h0, '0);
    // bounce on channel 1
    cyc(1'b1, 4'h2, '0);
    cyc(1'b1, 4'h0, '0);
    cyc(1'b1, 4'h2, '0);
    cyc(1'b1, 4'h0, '0);
    repeat (10) cyc(1'b1, 4'h2, '0);
    repeat (10) cyc(1'b1, 4'h0, '0);
    // release glitch on channel 2
    repeat (10) cyc(1'b1, 4'h4, '0);
    repeat (3) cyc(1'b1, 4'h0, '0);
    repeat (10) cyc(1'b1, 4'h4, '0);
    repeat (10) cyc(1'b1, 4'h0, '0);
    // all channels at once
    repeat (10) cyc(1'b1, 4'hF, '0);
    repeat (10) cyc(1'b1, 4'h0, '0);
    // clear coincident with a new pulse, then alone
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mpl[0][3]) begin
        seen = 1'b1;
        cyc(1'b1, 4'h8, 4'h8);
        cyc(1'b1, 4'h8, 4'h8);
        break;
      end
      cyc(1'b1, 4'h8, '0);
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL sticky_pulse_timeout got=0 exp=1");
    end
    repeat (10) cyc(1'b1, 4'h0, '0);
    // reset in the middle of a press debounce
    repeat (4) cyc(1'b1, 4'h1, '0);
    cyc(1'b0, 4'h1, '0);
    repeat (12) cyc(1'b1, 4'h1, '0);
    repeat (10) cyc(1'b1, 4'h0, '0);
    // random bouncing, clears and rare resets
    r = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(5) == 0) r[i] = ~r[i];
      c = ($urandom_range(7) == 0) ?
          NB'($urandom) : '0;
      rn = ($urandom_range(399) != 0);
      cyc(rn, r, c);
    end
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
